// File: rtl/prim_pkg.sv
// Shared definitions for the byte-serial SRAM bridge: FSM states, byte-select codes.
package prim_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LO   = 2'd1,
      ST_HI   = 2'd2,
      ST_ACK  = 2'd3
   } state_e;

   localparam logic [1:0] BS_NONE = 2'b00;
   localparam logic [1:0] BS_LO   = 2'b01;
   localparam logic [1:0] BS_HI   = 2'b10;
   localparam logic [1:0] BS_WORD = 2'b11;

   // High-byte address: next byte (wrapping) for a word access, the base address for a high-only access.
   function automatic logic [15:0] hi_addr(input logic [15:0] addr, input logic [1:0] bs);
      return (bs == BS_WORD) ? addr + 16'd1 : addr;
   endfunction

endpackage

// File: rtl/prim_mem_bridge.sv
// 16-bit CPU port to 8-bit asynchronous SRAM bridge, one or two byte phases per access.
// Optional write protection below WP_TOP when PRIM_MEM_BRIDGE_WP_EN is defined (adds o_wp_err).
module prim_mem_bridge
   import prim_pkg::*;
#(
   parameter int unsigned WAIT   = 1,
   parameter logic [15:0] WP_TOP = 16'h0100
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [15:0] i_addr,
   input  logic [15:0] i_dat,
   output logic [15:0] o_dat,
   input  logic [1:0]  i_bs,
   input  logic        i_we,
   output logic        o_ack,
   output logic [15:0] o_mem_addr,
   output logic [7:0]  o_mem_dat,
   input  logic [7:0]  i_mem_dat,
   output logic        o_mem_ce,
   output logic        o_mem_oe,
   output logic        o_mem_we
`ifdef PRIM_MEM_BRIDGE_WP_EN
   ,output logic       o_wp_err
`endif
);

`ifdef PRIM_MEM_BRIDGE_WP_EN
   localparam bit WP_EN = 1'b1;
`else
   localparam bit WP_EN = 1'b0;
`endif

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdat_q, wdat_d;
   logic [1:0]  bs_q, bs_d;
   logic        req_we_q, req_we_d;
   logic        ce_q, ce_d, oe_q, oe_d, mwe_q, mwe_d, ack_q, ack_d;
   logic [15:0] maddr_q, maddr_d;
   logic [7:0]  mdat_q, mdat_d;
   logic [15:0] rdat_q, rdat_d;
   logic        cap_lo_q, cap_lo_d, cap_hi_q, cap_hi_d;
   logic        last;
   logic [15:0] tgt_addr;
   logic        prot;

   assign last     = (cnt_q == 4'(WAIT));
   assign tgt_addr = (state_q == ST_HI) ? hi_addr(addr_q, bs_q) : addr_q;
   assign prot     = WP_EN && req_we_q && (tgt_addr < WP_TOP);

   // Strobes, address and capture flags are registered from the current state,
   // so the SRAM pins follow the FSM by one cycle.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      wdat_d   = wdat_q;
      bs_d     = bs_q;
      req_we_d = req_we_q;
      ce_d     = 1'b0;
      oe_d     = 1'b0;
      mwe_d    = 1'b0;
      ack_d    = 1'b0;
      maddr_d  = maddr_q;
      mdat_d   = mdat_q;
      cap_lo_d = 1'b0;
      cap_hi_d = 1'b0;
      rdat_d   = rdat_q;

      if (cap_lo_q) begin
         rdat_d = (bs_q == BS_WORD) ? {rdat_q[15:8], i_mem_dat} : {8'h00, i_mem_dat};
      end else if (cap_hi_q) begin
         rdat_d = (bs_q == BS_HI) ? {i_mem_dat, 8'h00} : {i_mem_dat, rdat_q[7:0]};
      end

      case (state_q)
         ST_IDLE: begin
            if (i_bs != BS_NONE) begin
               addr_d   = i_addr;
               wdat_d   = i_dat;
               bs_d     = i_bs;
               req_we_d = i_we;
               cnt_d    = '0;
               state_d  = (i_bs == BS_HI) ? ST_HI : ST_LO;
            end
         end
         ST_LO, ST_HI: begin
            ce_d    = 1'b1;
            oe_d    = ~req_we_q;
            mwe_d   = req_we_q & ~prot;
            maddr_d = tgt_addr;
            mdat_d  = (state_q == ST_LO) ? wdat_q[7:0] : wdat_q[15:8];
            if (last) begin
               cnt_d = '0;
               if (state_q == ST_LO) begin
                  cap_lo_d = ~req_we_q;
                  state_d  = (bs_q == BS_WORD) ? ST_HI : ST_ACK;
               end else begin
                  cap_hi_d = ~req_we_q;
                  state_d  = ST_ACK;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_ACK: begin
            ack_d   = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         wdat_q   <= '0;
         bs_q     <= BS_NONE;
         req_we_q <= 1'b0;
         ce_q     <= 1'b0;
         oe_q     <= 1'b0;
         mwe_q    <= 1'b0;
         ack_q    <= 1'b0;
         maddr_q  <= '0;
         mdat_q   <= '0;
         rdat_q   <= '0;
         cap_lo_q <= 1'b0;
         cap_hi_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         wdat_q   <= wdat_d;
         bs_q     <= bs_d;
         req_we_q <= req_we_d;
         ce_q     <= ce_d;
         oe_q     <= oe_d;
         mwe_q    <= mwe_d;
         ack_q    <= ack_d;
         maddr_q  <= maddr_d;
         mdat_q   <= mdat_d;
         rdat_q   <= rdat_d;
         cap_lo_q <= cap_lo_d;
         cap_hi_q <= cap_hi_d;
      end
   end

`ifdef PRIM_MEM_BRIDGE_WP_EN
   logic wp_hit_q, wp_hit_d, wp_err_q;

   always_comb begin
      wp_hit_d = wp_hit_q;
      if (state_q == ST_IDLE && i_bs != BS_NONE) begin
         wp_hit_d = 1'b0;
      end else if ((state_q == ST_LO || state_q == ST_HI) && prot) begin
         wp_hit_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         wp_hit_q <= 1'b0;
         wp_err_q <= 1'b0;
      end else begin
         wp_hit_q <= wp_hit_d;
         wp_err_q <= (state_q == ST_ACK) && wp_hit_q;
      end
   end

   assign o_wp_err = wp_err_q;
`endif

   assign o_dat      = rdat_q;
   assign o_ack      = ack_q;
   assign o_mem_addr = maddr_q;
   assign o_mem_dat  = mdat_q;
   assign o_mem_ce   = ce_q;
   assign o_mem_oe   = oe_q;
   assign o_mem_we   = mwe_q;

endmodule

// File: tb/tb_prim_mem_bridge.sv
// Directed bench for prim_mem_bridge: three instances (WAIT=0,1,2) on one shared SRAM model.
module tb_prim_mem_bridge;

   logic        clk, rst;
   logic [15:0] addr, wdat;
   logic        we;
   logic [1:0]  bs_w   [3];
   logic [15:0] dat_w  [3];
   logic [15:0] maddr_w[3];
   logic [7:0]  mdat_w [3];
   logic [7:0]  mrd_w  [3];
   logic        ack_w  [3];
   logic        ce_w   [3];
   logic        oe_w   [3];
   logic        mwe_w  [3];
`ifdef PRIM_MEM_BRIDGE_WP_EN
   logic        wp_w   [3];
`endif

   logic [7:0]  mem [0:65535];
   logic        pl_en;
   logic [15:0] pl_addr;
   logic [7:0]  pl_dat;

   int          n_cmp, n_bad;
   int          lat;
   logic [15:0] ack_dat;
   logic        ack2, ack_wp, wp2;
   logic        tr_ce[64], tr_oe[64], tr_we[64];
   logic [15:0] tr_addr[64];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      prim_mem_bridge #(.WAIT(g)) u_dut (
         .i_clk(clk), .i_reset(rst), .i_addr(addr), .i_dat(wdat), .o_dat(dat_w[g]),
         .i_bs(bs_w[g]), .i_we(we), .o_ack(ack_w[g]), .o_mem_addr(maddr_w[g]),
         .o_mem_dat(mdat_w[g]), .i_mem_dat(mrd_w[g]), .o_mem_ce(ce_w[g]),
         .o_mem_oe(oe_w[g]), .o_mem_we(mwe_w[g])
`ifdef PRIM_MEM_BRIDGE_WP_EN
         , .o_wp_err(wp_w[g])
`endif
      );
      assign mrd_w[g] = mem[maddr_w[g]];
   end

   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_dat;
      for (int k = 0; k < 3; k++) begin
         if (ce_w[k] && mwe_w[k]) mem[maddr_w[k]] <= mdat_w[k];
      end
   end

   task automatic preload(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk); pl_en = 1'b1; pl_addr = a; pl_dat = d;
      @(posedge clk); #1 pl_en = 1'b0;
   endtask

   // One request on instance k; traces pins per cycle after the sampling edge until o_ack.
   task automatic do_req(input int k, input logic [15:0] a, input logic [15:0] d,
                         input logic [1:0] bs, input logic w);
      @(negedge clk); addr = a; wdat = d; we = w; bs_w[k] = bs;
      @(posedge clk); #1 bs_w[k] = 2'b00;
      lat = -1; ack_dat = '0; ack_wp = 1'b0; wp2 = 1'b0;
      for (int n = 0; n < 64; n++) begin
         tr_ce[n] = 1'b0; tr_oe[n] = 1'b0; tr_we[n] = 1'b0; tr_addr[n] = '0;
      end
      for (int n = 1; n < 40; n++) begin
         @(posedge clk); #1;
         tr_ce[n] = ce_w[k]; tr_oe[n] = oe_w[k]; tr_we[n] = mwe_w[k]; tr_addr[n] = maddr_w[k];
         if (ack_w[k]) begin
            lat = n; ack_dat = dat_w[k];
`ifdef PRIM_MEM_BRIDGE_WP_EN
            ack_wp = wp_w[k];
`endif
            break;
         end
      end
      @(posedge clk); #1 ack2 = ack_w[k];
`ifdef PRIM_MEM_BRIDGE_WP_EN
      wp2 = wp_w[k];
`endif
   endtask

   function automatic int n_oe_at(input logic [15:0] a);
      int c = 0;
      for (int n = 1; n < 64; n++) if (tr_ce[n] && tr_oe[n] && tr_addr[n] == a) c++;
      return c;
   endfunction

   function automatic int n_we_at(input logic [15:0] a);
      int c = 0;
      for (int n = 1; n < 64; n++) if (tr_ce[n] && tr_we[n] && tr_addr[n] == a) c++;
      return c;
   endfunction

   function automatic int n_any(input int which);
      int c = 0;
      for (int n = 1; n < 64; n++) begin
         if (which == 0 && tr_ce[n]) c++;
         if (which == 1 && tr_oe[n]) c++;
         if (which == 2 && tr_we[n]) c++;
      end
      return c;
   endfunction

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         n_cmp++; if ({ack_w[k], ce_w[k], oe_w[k], mwe_w[k]} !== 4'b0000) begin n_bad++; $display("FAIL rst_strobes[%0d]: got %b want 0000", k, {ack_w[k], ce_w[k], oe_w[k], mwe_w[k]}); end
         n_cmp++; if (dat_w[k] !== 16'h0000) begin n_bad++; $display("FAIL rst_dat[%0d]: got %h want 0000", k, dat_w[k]); end
         n_cmp++; if ({maddr_w[k], mdat_w[k]} !== 24'h0) begin n_bad++; $display("FAIL rst_mem[%0d]: got %h want 000000", k, {maddr_w[k], mdat_w[k]}); end
      end
      @(negedge clk); rst = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_reads_w0;
      preload(16'h0020, 8'h11); preload(16'h0021, 8'h22);
      preload(16'h0010, 8'hA5); preload(16'h0030, 8'h5A);
      do_req(0, 16'h0020, 16'h0000, 2'b11, 1'b0);
      n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL w0_rd16_lat: got %0d want 3", lat); end
      n_cmp++; if (ack_dat !== 16'h2211) begin n_bad++; $display("FAIL w0_rd16_dat: got %h want 2211", ack_dat); end
      do_req(0, 16'h0010, 16'h0000, 2'b01, 1'b0);
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL w0_rd8_lat: got %0d want 2", lat); end
      n_cmp++; if (ack_dat !== 16'h00A5) begin n_bad++; $display("FAIL w0_rd8_dat: got %h want 00a5", ack_dat); end
      n_cmp++; if (n_oe_at(16'h0010) !== 1 || n_any(2) !== 0) begin n_bad++; $display("FAIL w0_rd8_strobes: got oe=%0d we=%0d want 1/0", n_oe_at(16'h0010), n_any(2)); end
      n_cmp++; if (ack2 !== 1'b0) begin n_bad++; $display("FAIL w0_ack_width: got %b want 0", ack2); end
      do_req(0, 16'h0030, 16'h0000, 2'b10, 1'b0);
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL w0_rdhi_lat: got %0d want 2", lat); end
      n_cmp++; if (ack_dat !== 16'h5A00) begin n_bad++; $display("FAIL w0_rdhi_dat: got %h want 5a00", ack_dat); end
      n_cmp++; if (n_oe_at(16'h0030) !== 1) begin n_bad++; $display("FAIL w0_rdhi_addr: got %0d want 1", n_oe_at(16'h0030)); end
   endtask

   task automatic test_word_wrap;
      preload(16'hFFFF, 8'h34); preload(16'h0000, 8'h12);
      do_req(1, 16'hFFFF, 16'h0000, 2'b11, 1'b0);
      n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL wrap_lat: got %0d want 5", lat); end
      n_cmp++; if (ack_dat !== 16'h1234) begin n_bad++; $display("FAIL wrap_dat: got %h want 1234", ack_dat); end
      n_cmp++; if (n_oe_at(16'hFFFF) !== 2) begin n_bad++; $display("FAIL wrap_lo_cycles: got %0d want 2", n_oe_at(16'hFFFF)); end
      n_cmp++; if (n_oe_at(16'h0000) !== 2) begin n_bad++; $display("FAIL wrap_hi_cycles: got %0d want 2", n_oe_at(16'h0000)); end
   endtask

   task automatic test_word_write;
      preload(16'h0040, 8'h77); preload(16'h0200, 8'h00); preload(16'h0201, 8'h00);
      do_req(2, 16'h0040, 16'h0000, 2'b01, 1'b0);
      n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL w2_rd8_lat: got %0d want 4", lat); end
      n_cmp++; if (ack_dat !== 16'h0077) begin n_bad++; $display("FAIL w2_rd8_dat: got %h want 0077", ack_dat); end
      do_req(2, 16'h0200, 16'hBEEF, 2'b11, 1'b1);
      n_cmp++; if (lat !== 7) begin n_bad++; $display("FAIL w2_wr16_lat: got %0d want 7", lat); end
      n_cmp++; if ({mem[16'h0201], mem[16'h0200]} !== 16'hBEEF) begin n_bad++; $display("FAIL w2_wr16_mem: got %h want beef", {mem[16'h0201], mem[16'h0200]}); end
      n_cmp++; if (n_we_at(16'h0200) !== 3 || n_we_at(16'h0201) !== 3) begin n_bad++; $display("FAIL w2_we_width: got %0d/%0d want 3/3", n_we_at(16'h0200), n_we_at(16'h0201)); end
      n_cmp++; if (n_any(1) !== 0) begin n_bad++; $display("FAIL w2_wr_oe: got %0d want 0", n_any(1)); end
      n_cmp++; if (dat_w[2] !== 16'h0077) begin n_bad++; $display("FAIL w2_wr_odat: got %h want 0077", dat_w[2]); end
   endtask

   task automatic test_reset_mid;
      logic seen_ack = 1'b0;
      @(negedge clk); addr = 16'h0060; we = 1'b0; bs_w[1] = 2'b11;
      @(posedge clk); #1 bs_w[1] = 2'b00;
      @(posedge clk); #1;
      n_cmp++; if (ce_w[1] !== 1'b1) begin n_bad++; $display("FAIL mid_ce_before: got %b want 1", ce_w[1]); end
      #1 rst = 1'b1;
      #1;
      n_cmp++; if ({ce_w[1], oe_w[1], mwe_w[1], ack_w[1]} !== 4'b0000) begin n_bad++; $display("FAIL mid_strobes: got %b want 0000", {ce_w[1], oe_w[1], mwe_w[1], ack_w[1]}); end
      n_cmp++; if (maddr_w[1] !== 16'h0000) begin n_bad++; $display("FAIL mid_maddr: got %h want 0000", maddr_w[1]); end
      @(negedge clk); rst = 1'b0;
      for (int n = 0; n < 8; n++) begin
         @(posedge clk); #1 if (ack_w[1]) seen_ack = 1'b1;
      end
      n_cmp++; if (seen_ack !== 1'b0) begin n_bad++; $display("FAIL mid_no_ack: got %b want 0", seen_ack); end
      preload(16'h0050, 8'h9C);
      do_req(1, 16'h0050, 16'h0000, 2'b01, 1'b0);
      n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL mid_next_lat: got %0d want 3", lat); end
      n_cmp++; if (ack_dat !== 16'h009C) begin n_bad++; $display("FAIL mid_next_dat: got %h want 009c", ack_dat); end
   endtask

   task automatic test_back_to_back;
      logic [4:0] ack_v = '0, ce_v = '0;
      @(negedge clk); addr = 16'h0010; we = 1'b0; bs_w[0] = 2'b01;
      @(posedge clk);
      for (int n = 1; n <= 5; n++) begin
         @(posedge clk); #1;
         ack_v[n-1] = ack_w[0]; ce_v[n-1] = ce_w[0];
      end
      bs_w[0] = 2'b00;
      n_cmp++; if (ack_v !== 5'b10010) begin n_bad++; $display("FAIL b2b_ack: got %b want 10010", ack_v); end
      n_cmp++; if (ce_v !== 5'b01001) begin n_bad++; $display("FAIL b2b_ce: got %b want 01001", ce_v); end
      n_cmp++; if (dat_w[0] !== 16'h00A5) begin n_bad++; $display("FAIL b2b_dat: got %h want 00a5", dat_w[0]); end
      repeat (4) @(posedge clk);
   endtask

`ifdef PRIM_MEM_BRIDGE_WP_EN
   task automatic test_wp;
      preload(16'h00FF, 8'h00); preload(16'h0100, 8'h00);
      do_req(0, 16'h00FF, 16'h1234, 2'b11, 1'b1);
      n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL wp_lat: got %0d want 3", lat); end
      n_cmp++; if ({mem[16'h0100], mem[16'h00FF]} !== 16'h1200) begin n_bad++; $display("FAIL wp_mem: got %h want 1200", {mem[16'h0100], mem[16'h00FF]}); end
      n_cmp++; if ({ack_wp, wp2} !== 2'b10) begin n_bad++; $display("FAIL wp_err_pulse: got %b want 10", {ack_wp, wp2}); end
      n_cmp++; if (n_any(0) !== 2) begin n_bad++; $display("FAIL wp_ce_cycles: got %0d want 2", n_any(0)); end
   endtask
`endif

   initial begin
      n_cmp = 0; n_bad = 0;
      rst = 1'b1; addr = '0; wdat = '0; we = 1'b0;
      pl_en = 1'b0; pl_addr = '0; pl_dat = '0;
      for (int k = 0; k < 3; k++) bs_w[k] = 2'b00;
      test_reset;
      test_reads_w0;
      test_word_wrap;
      test_word_write;
      test_reset_mid;
      test_back_to_back;
`ifdef PRIM_MEM_BRIDGE_WP_EN
      test_wp;
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
